// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data memory with configurable latency, ack pulse and pipeline stall
module dmem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        ready_o,
    output logic        ack_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic        stall_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state, state_nx;
    logic [3:0]  cnt;
    logic        lat_we;
    logic [31:0] lat_addr, lat_wdata;
    logic        acc_we, acc_err, accept, enter_resp;
    logic [31:0] acc_addr, acc_wdata;
    logic [AW-1:0] idx;
    logic [31:0] mem [DEPTH];

    assign accept     = state == IDLE && req_i;
    assign ready_o    = state == IDLE;
    assign stall_o    = accept || state == WAIT;
    assign acc_we     = state == IDLE ? we_i    : lat_we;
    assign acc_addr   = state == IDLE ? addr_i  : lat_addr;
    assign acc_wdata  = state == IDLE ? wdata_i : lat_wdata;
    assign idx        = acc_addr[AW+1:2];
    assign acc_err    = acc_addr[1:0] != 2'b00 || {2'b00, acc_addr[31:2]} >= 32'(DEPTH);
    assign enter_resp = state_nx == RESP && state != RESP;

    // Next-state: IDLE accepts, WAIT counts down to 1, RESP always returns to IDLE
    always_comb begin
        state_nx = state;
        if (accept)
            state_nx = LATENCY > 1 ? WAIT : RESP;
        else if (state == WAIT && cnt == 4'd1)
            state_nx = RESP;
        else if (state == RESP)
            state_nx = IDLE;
    end

    // State, latency counter, latched request and the registered response
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state     <= IDLE;
            cnt       <= '0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            ack_o     <= 1'b0;
            rdata_o   <= '0;
            err_o     <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= accept ? CNT_INIT : state == WAIT ? cnt - 4'd1 : cnt;
            ack_o   <= enter_resp;
            err_o   <= enter_resp && acc_err;
            rdata_o <= enter_resp && !acc_err && !acc_we ? mem[idx] : '0;
            if (accept) begin
                lat_we    <= we_i;
                lat_addr  <= addr_i;
                lat_wdata <= wdata_i;
            end
        end
    end

    // Backing array is not reset; a store commits on the edge that enters RESP
    always_ff @(posedge clk_i) begin
        if (enter_resp && !acc_err && acc_we)
            mem[idx] <= acc_wdata;
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized self-checking bench against a word-array reference model
module tb_dmem_responder;
    logic        clk = 1'b0, rst_n = 1'b0, req0 = 1'b0, req1 = 1'b0, we = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic        rdy0, ack0, err0, stall0, rdy1, ack1, err1, stall1;
    logic [31:0] rd0, rd1;
    int          n_chk = 0, n_fail = 0;
    logic [31:0] model0 [256];
    logic [31:0] model1 [256];

    dmem_responder #(.DEPTH(256), .LATENCY(3)) dut (
        .clk_i(clk), .rst_i(rst_n), .req_i(req0), .we_i(we), .addr_i(addr), .wdata_i(wdata),
        .ready_o(rdy0), .ack_o(ack0), .rdata_o(rd0), .err_o(err0), .stall_o(stall0));

    dmem_responder #(.DEPTH(256), .LATENCY(1)) dut1 (
        .clk_i(clk), .rst_i(rst_n), .req_i(req1), .we_i(we), .addr_i(addr), .wdata_i(wdata),
        .ready_o(rdy1), .ack_o(ack1), .rdata_o(rd1), .err_o(err1), .stall_o(stall1));

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    function automatic bit exp_err(input logic [31:0] a);
        return a[1:0] != 2'b00 || a[31:2] >= 30'd256;
    endfunction

    function automatic logic [31:0] exp_rd(input bit s, input logic [31:0] a);
        if (exp_err(a)) return '0;
        return s ? model1[a[9:2]] : model0[a[9:2]];
    endfunction

    task automatic wait_ack(input bit s, input bit scr, output int cyc, output int stl,
                            output logic [31:0] rd, output logic er);
        bit a;
        cyc = 0;
        stl = 0;
        do begin
            @(negedge clk);
            cyc++;
            a = s ? ack1 : ack0;
            if (s ? stall1 : stall0) stl++;
            if (!a && scr) begin
                we    = 1'($urandom);
                addr  = $urandom;
                wdata = $urandom;
            end
        end while (!a && cyc < 40);
        rd = s ? rd1 : rd0;
        er = s ? err1 : err0;
    endtask

    task automatic access(input bit s, input bit w, input logic [31:0] a, input logic [31:0] d,
                          input bit hold, input bit scr, output int cyc, output int stl,
                          output logic [31:0] rd, output logic er);
        int st0;
        @(negedge clk);
        we    = w;
        addr  = a;
        wdata = d;
        if (s) req1 = 1'b1;
        else req0 = 1'b1;
        #1 st0 = (s ? stall1 : stall0) ? 1 : 0;
        wait_ack(s, scr, cyc, stl, rd, er);
        stl += st0;
        if (!hold) begin
            req0 = 1'b0;
            req1 = 1'b0;
        end
        if (cyc < 40 && w && !exp_err(a)) begin
            if (s) model1[a[9:2]] = d;
            else model0[a[9:2]] = d;
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        #1;
        n_chk += 5;
        if (ack0 !== 1'b0) begin n_fail++; $display("FAIL reset_ack got %b want 0", ack0); end
        if (rd0 !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got %h want 0", rd0); end
        if (err0 !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", err0); end
        if (rdy0 !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", rdy0); end
        if (stall0 !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", stall0); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_store_load;
        int cyc, stl;
        logic [31:0] rd;
        logic er;
        access(0, 1, 32'h10, 32'hDEADBEEF, 0, 0, cyc, stl, rd, er);
        n_chk += 4;
        if (cyc !== 3) begin n_fail++; $display("FAIL st_latency got %0d want 3", cyc); end
        if (stl !== 3) begin n_fail++; $display("FAIL st_stall_cycles got %0d want 3", stl); end
        if (er !== 1'b0) begin n_fail++; $display("FAIL st_err got %b want 0", er); end
        if (rd !== 32'h0) begin n_fail++; $display("FAIL st_rdata got %h want 0", rd); end
        access(0, 0, 32'h10, 32'h0, 0, 0, cyc, stl, rd, er);
        n_chk += 4;
        if (cyc !== 3) begin n_fail++; $display("FAIL ld_latency got %0d want 3", cyc); end
        if (stl !== 3) begin n_fail++; $display("FAIL ld_stall_cycles got %0d want 3", stl); end
        if (er !== 1'b0) begin n_fail++; $display("FAIL ld_err got %b want 0", er); end
        if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL ld_rdata got %h want deadbeef", rd); end
        @(negedge clk);
        n_chk += 2;
        if (ack0 !== 1'b0) begin n_fail++; $display("FAIL ack_single_cycle got %b want 0", ack0); end
        if (rd0 !== 32'h0) begin n_fail++; $display("FAIL rdata_cleared got %h want 0", rd0); end
    endtask

    task automatic test_errors;
        int cyc, stl;
        logic [31:0] rd;
        logic er;
        logic [31:0] addrs [5] = '{32'h100, 32'h102, 32'h12, 32'h400, 32'h100};
        bit          wes   [5] = '{1, 1, 0, 0, 0};
        for (int i = 0; i < 5; i++) begin
            logic [31:0] e;
            access(0, wes[i], addrs[i], i == 0 ? 32'hA5A5A5A5 : 32'h0BAD0BAD, 0, 0, cyc, stl, rd, er);
            e = wes[i] ? 32'h0 : exp_rd(0, addrs[i]);
            n_chk += 3;
            if (cyc !== 3) begin n_fail++; $display("FAIL err_latency[%0d] got %0d want 3", i, cyc); end
            if (er !== exp_err(addrs[i])) begin n_fail++; $display("FAIL err_flag[%0d] got %b want %b", i, er, exp_err(addrs[i])); end
            if (rd !== e) begin n_fail++; $display("FAIL err_rdata[%0d] got %h want %h", i, rd, e); end
        end
    endtask

    task automatic test_reset_abort;
        int cyc, stl;
        logic [31:0] rd;
        logic er;
        access(0, 1, 32'h20, 32'hCAFEF00D, 0, 0, cyc, stl, rd, er);
        @(negedge clk);
        we    = 1'b1;
        addr  = 32'h20;
        wdata = 32'h11111111;
        req0  = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        req0  = 1'b0;
        #1;
        n_chk += 4;
        if (ack0 !== 1'b0) begin n_fail++; $display("FAIL abort_ack got %b want 0", ack0); end
        if (rd0 !== 32'h0) begin n_fail++; $display("FAIL abort_rdata got %h want 0", rd0); end
        if (err0 !== 1'b0) begin n_fail++; $display("FAIL abort_err got %b want 0", err0); end
        if (stall0 !== 1'b0) begin n_fail++; $display("FAIL abort_stall got %b want 0", stall0); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        access(0, 0, 32'h20, 32'h0, 0, 0, cyc, stl, rd, er);
        n_chk++;
        if (rd !== model0[8]) begin n_fail++; $display("FAIL abort_rdata_kept got %h want %h", rd, model0[8]); end
    endtask

    task automatic test_back_to_back;
        int cyc, stl;
        logic [31:0] rd, d;
        logic er;
        d = $urandom;
        access(0, 1, 32'h30, d, 1, 0, cyc, stl, rd, er);
        n_chk++;
        if (cyc !== 3) begin n_fail++; $display("FAIL b2b_first_latency got %0d want 3", cyc); end
        we   = 1'b0;
        addr = 32'h30;
        wait_ack(0, 0, cyc, stl, rd, er);
        req0 = 1'b0;
        n_chk += 2;
        if (cyc !== 4) begin n_fail++; $display("FAIL b2b_ack_spacing got %0d want 4", cyc); end
        if (rd !== d) begin n_fail++; $display("FAIL b2b_rdata got %h want %h", rd, d); end
        @(negedge clk);
        n_chk++;
        if (ack0 !== 1'b0) begin n_fail++; $display("FAIL b2b_ack_single got %b want 0", ack0); end
    endtask

    task automatic test_latency1;
        int cyc, stl;
        logic [31:0] rd, d;
        logic er;
        d = $urandom;
        access(1, 1, 32'h40, d, 0, 0, cyc, stl, rd, er);
        n_chk += 2;
        if (cyc !== 1) begin n_fail++; $display("FAIL l1_st_latency got %0d want 1", cyc); end
        if (stl !== 1) begin n_fail++; $display("FAIL l1_st_stall got %0d want 1", stl); end
        access(1, 0, 32'h40, 32'h0, 0, 0, cyc, stl, rd, er);
        n_chk += 3;
        if (cyc !== 1) begin n_fail++; $display("FAIL l1_ld_latency got %0d want 1", cyc); end
        if (stl !== 1) begin n_fail++; $display("FAIL l1_ld_stall got %0d want 1", stl); end
        if (rd !== d) begin n_fail++; $display("FAIL l1_ld_rdata got %h want %h", rd, d); end
        access(1, 0, 32'h41, 32'h0, 0, 0, cyc, stl, rd, er);
        n_chk++;
        if (er !== 1'b1) begin n_fail++; $display("FAIL l1_err got %b want 1", er); end
    endtask

    task automatic test_random;
        int cyc, stl;
        logic [31:0] rd, a, d, e;
        logic er;
        bit w;
        for (int i = 0; i < 16; i++)
            access(0, 1, 32'h200 + 32'(i * 4), $urandom, 0, 0, cyc, stl, rd, er);
        for (int i = 0; i < 40; i++) begin
            int k;
            k = $urandom_range(0, 9);
            a = 32'h200 + 32'($urandom_range(0, 15) * 4);
            if (k == 0) a = a + 32'($urandom_range(1, 3));
            if (k == 1) a = $urandom | 32'h400;
            w = 1'($urandom);
            d = $urandom;
            e = w ? 32'h0 : exp_rd(0, a);
            access(0, w, a, d, 0, 1'($urandom), cyc, stl, rd, er);
            n_chk += 4;
            if (cyc !== 3) begin n_fail++; $display("FAIL rnd_latency[%0d] got %0d want 3", i, cyc); end
            if (stl !== 3) begin n_fail++; $display("FAIL rnd_stall[%0d] got %0d want 3", i, stl); end
            if (er !== exp_err(a)) begin n_fail++; $display("FAIL rnd_err[%0d] addr %h got %b want %b", i, a, er, exp_err(a)); end
            if (rd !== e) begin n_fail++; $display("FAIL rnd_rdata[%0d] addr %h got %h want %h", i, a, rd, e); end
        end
    endtask

    initial begin
        test_reset;
        test_store_load;
        test_errors;
        test_reset_abort;
        test_back_to_back;
        test_latency1;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
